// File: rtl/wb_fifo.sv
// Result buffer for the memory/long-latency producer.
// Holds {rd, data} entries in arrival order until the write port is free.
// Depth must be a power of two so head/tail wrap naturally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = storage[head];

  // Entry storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[tail] <= push_data;
    end
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop_ok) begin
        head <= head + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-side companion of the integer register file.
// Merges ALU results (never stalled) and buffered memory results onto the
// single write port, ALU first, and keeps the pending-write scoreboard that
// decode queries for RAW hazards.
module reg_writeback #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int REG_COUNT  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] busy_addr1,
  output logic                  busy1,
  input  logic [REG_ADDR_W-1:0] busy_addr2,
  output logic                  busy2
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  alu_sel;
  logic [REG_COUNT-1:0]  busy;
  logic [REG_COUNT-1:0]  busy_next;

  // Readiness looks only at occupancy before the edge, so a pop never frees a slot early.
  assign mem_ready = !fifo_full;

  // Results for x0 are accepted from the producer but never buffered.
  assign fifo_push = mem_valid && mem_ready && (mem_rd != '0);

  // ALU owns the port whenever it has a real destination; the buffer drains otherwise.
  assign alu_sel  = alu_valid && (alu_rd != '0);
  assign fifo_pop = !alu_sel && !fifo_empty;

  assign head_rd   = fifo_head[ENTRY_W-1:XLEN];
  assign head_data = fifo_head[XLEN-1:0];

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({mem_rd, mem_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  // Registered write port; address and data hold when no write is selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (alu_sel) begin
      write_en   <= 1'b1;
      write_addr <= alu_rd;
      write_data <= alu_data;
    end else if (fifo_pop) begin
      write_en   <= 1'b1;
      write_addr <= head_rd;
      write_data <= head_data;
    end else begin
      write_en   <= 1'b0;
    end
  end

  // Scoreboard update: the retiring write clears, a new issue sets and wins a tie.
  always_comb begin
    busy_next = busy;
    if (write_en) begin
      busy_next[write_addr] = 1'b0;
    end
    if (issue_en && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register, cleared wholesale by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy1 = busy[busy_addr1];
  assign busy2 = busy[busy_addr2];

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side companion to the integer register file. Collects completed results from two producers and drives the register file's single write port, one write per cycle:
  - ALU: single-cycle, cannot be stalled.
  - Memory/long-latency unit: valid/ready handshake.
- Maintains a per-register pending-write scoreboard. Decode reads it alongside the two register-file read ports to stall on RAW hazards.

Parameters:
- XLEN, 32, data width of results and of write_data.
- REG_ADDR_W, 5, register index width.
- REG_COUNT, 32, number of architectural registers (2**REG_ADDR_W).
- FIFO_DEPTH, 4, entries in the memory-result buffer; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  REG_ADDR_W  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  memory result offered.
- mem_ready  out  1  memory result accepted when mem_valid & mem_ready.
- mem_rd  in  REG_ADDR_W  memory destination register.
- mem_data  in  XLEN  memory result.
- write_en  out  1  register-file write enable.
- write_addr  out  REG_ADDR_W  register-file write index.
- write_data  out  XLEN  register-file write data.
- issue_en  in  1  instruction with destination issued.
- issue_rd  in  REG_ADDR_W  destination of the issued instruction.
- busy_addr1  in  REG_ADDR_W  scoreboard query index 1.
- busy1  out  1  register busy_addr1 has a pending write.
- busy_addr2  in  REG_ADDR_W  scoreboard query index 2.
- busy2  out  1  register busy_addr2 has a pending write.

Behaviour:
- Reset (async) sets:
  - write_en=0, write_addr=0, write_data=0.
  - FIFO empty: head=tail=count=0.
  - All busy bits 0.
- mem_ready = (count != FIFO_DEPTH), combinational. It is therefore 1 during and after reset.
- Memory acceptance: mem_valid & mem_ready.
  - mem_rd != 0: enqueue {rd, data} at tail.
  - mem_rd == 0: accepted and discarded, not enqueued.
- Write port outputs are registered. Each cycle, selection in priority order:
  1. ALU, if alu_valid & alu_rd != 0: on the next edge write_en=1, write_addr=alu_rd, write_data=alu_data.
  2. Otherwise, if FIFO not empty: the head entry drives the outputs on the next edge, and head is popped.
  3. Otherwise write_en=0 on the next edge. write_addr and write_data hold their previous values.
- ALU with rd==0: dropped, no write, the FIFO may drain that cycle.
- Latency:
  - ALU result to write_en: 1 cycle.
  - Memory result with empty FIFO and no ALU activity: accepted at edge N, written out at edge N+1.
- Enqueue and pop in the same cycle are allowed: count unchanged. Enqueue into a full FIFO is impossible because mem_ready=0. A pop in the same cycle does not raise mem_ready; readiness uses count before the edge.
- head and tail wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Continuous ALU traffic starves the FIFO. This is by design; the pipeline bounds ALU bursts.
- Scoreboard: busy[REG_COUNT].
  - issue_en & issue_rd != 0 sets busy[issue_rd] at the edge.
  - busy[write_addr] clears at the edge where write_en=1. This is the same edge at which the register file captures the data.
  - If set and clear hit the same index at the same edge, set wins.
  - busy[0] is always 0.
- busy1 = busy[busy_addr1] and busy2 = busy[busy_addr2]. Both are combinational, with no write bypass.
- Issuing to an already-busy rd (WAW) is illegal; decode stalls on it. The bench asserts it never happens.
- Asserting rst mid-operation discards FIFO contents and all pending busy bits. Producers must also be flushed.

Decomposition:
- Shared constants (XLEN, REG_ADDR width, REG_COUNT) come from the existing const/inst define headers. No new package.
- One natural sub-module: wb_fifo, a synchronous FIFO of width REG_ADDR_W+XLEN with depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, head data.
- Priority mux and scoreboard stay in reg_writeback.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> next cycle write_en=1, write_addr=5, write_data=0xDEADBEEF; following cycle write_en=0.
2. Memory result mem_rd=7, data=0x11 with ALU idle -> mem_ready=1, accepted; one cycle later write_en=1, write_addr=7, write_data=0x11.
3. Same cycle: ALU rd=3 data=0xA and mem rd=4 data=0xB -> cycle+1 writes x3=0xA, cycle+2 writes x4=0xB.
4. Hold alu_valid=1 (rd=1) for 6 cycles while offering mem results each cycle:
   - mem_ready drops after 4 acceptances.
   - After the ALU stops, the 4 entries drain in FIFO order on consecutive cycles.
   - mem_ready returns to 1.
5. rd==0 on both sources -> no write_en, FIFO count unchanged, busy1 for busy_addr1=0 stays 0.
6. Scoreboard check:
   - issue_en, issue_rd=9 -> busy1 (busy_addr1=9) = 1 from the next cycle.
   - Memory writes x9 -> busy1 = 1 while write_en is high, 0 the cycle after.
   - Re-issue of x9 on the clearing edge -> busy1 stays 1.
   - Async rst mid-drain -> FIFO empty, all busy bits 0, write_en=0 immediately.
